popcount_accumulator: RTL and testbench
=======================================

# popcount_accumulator

Parametrised, pipelined population-count accumulator for the NPU binary/bit-serial datapath. It accepts IN_W-bit vectors over a valid/ready stream and reduces each beat to a bit count using a tree of 15-input compressors. It accumulates the counts across a packet delimited by `in_last` and emits one saturated result per packet. A bipolar mode produces XNOR-net style dot products, computed as 2·pop − IN_W per beat.

## Interface
- `IN_W`, default 15: input vector width, 1..240. The vector splits into G = ceil(IN_W/15) groups of 15 bits; the last group is zero-padded.
- `ACC_W`, default 16: accumulator and result width, ≥ clog2(IN_W+1)+1.
- `clk`  in  1: clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_data`  in  IN_W: bit vector.
- `in_valid`  in  1: beat valid.
- `in_ready`  out  1: beat accepted when `in_valid & in_ready`.
- `in_last`  in  1: final beat of the packet.
- `in_mode`  in  1: 0 = unsigned popcount, 1 = bipolar signed. Sampled only on the first beat of a packet.
- `out_data`  out  ACC_W: packet result. Unsigned in mode 0, two's complement in mode 1.
- `out_sat`  out  1: saturation occurred during the packet.
- `out_mode`  out  1: mode of the reported packet.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: result consumed when `out_valid & out_ready`.

## Operation
- Stage S1 (registered): each group is reduced to a 4-bit count. `s1_valid`, `s1_last` and `s1_mode` are registered alongside the counts.
- Stage S2 (registered): the G group counts are summed into a beat count `pop` of width clog2(IN_W+1).
  - Mode 0 contribution: `pop`.
  - Mode 1 contribution: 2·`pop` − IN_W, sign-extended.
  - The contribution is added to the accumulator `acc`.
- Packet mode:
  - The mode is taken from `in_mode` on the first accepted beat after reset or after a `last`.
  - Later beats of the same packet ignore `in_mode`.
- Saturation:
  - Mode 0 clamps to 2^ACC_W − 1.
  - Mode 1 clamps to [−2^(ACC_W−1), 2^(ACC_W−1) − 1].
  - Once clamped, the sticky `sat` flag is set for the rest of the packet, and later beats still add from the clamped value.
- When an S2 beat with `last` arrives:
  - `out_data` is loaded with the final clamped sum; `out_sat` and `out_mode` are loaded with it, and `out_valid` is set.
  - `acc` and `sat` are cleared in the same cycle.
  - A one-beat packet is legal.
- Output handshake:
  - `out_valid` stays high, and `out_data` stays stable, until `out_ready` is sampled high.
  - A handshake with no new result arriving clears `out_valid`.
- Stall: `stall = out_valid & ~out_ready`.
  - `in_ready = ~stall`.
  - During a stall, S1, S2 and `acc` hold their values.
- Simultaneous events: if a result is consumed and a new last beat finishes S2 in the same cycle, the output register reloads and `out_valid` stays 1. No bubble is allowed.
- `in_valid` low inserts bubbles; a bubble leaves `acc` unchanged.

## Timing
- Reset values:
  - `out_data` = 0, `out_sat` = 0, `out_mode` = 0, `out_valid` = 0.
  - `in_ready` = 1 (combinational from `out_valid`).
  - Internal `acc`, `sat`, first-beat flag, and S1/S2 valid bits are cleared.
- Latency: a last beat accepted at edge t gives `out_valid` = 1 after edge t+2.
- Throughput: one beat per cycle when not stalled.
- Reset mid-packet discards the partial sum and any pending output. The next accepted beat starts a new packet.
- `in_ready` depends only on registered `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Structure
- Shared package `npu_pop_pkg`:
  - `GROUP_W` = 15.
  - `GCNT_W` = 4.
  - Mode encodings `MODE_POP` = 0, `MODE_BIP` = 1.
  - clog2 function.
  - Signed/unsigned saturation limit functions.
- Sub-module `popcount_group`: combinational 15→4 counter, instantiated G times in S1. It is built from full adders followed by a 5→3 and final carry-propagate stage, matching the existing compressor cells.
- Top level: S1/S2 registers, the group-sum adder tree, the accumulator with saturation, and the output register with handshake. Roughly 200–300 lines.

## Test plan
- IN_W=15, ACC_W=16, mode 0. One beat 15'h7FFF with last at edge t → `out_data` = 15, `out_valid` high after t+2, `out_sat` = 0.
- Mode 1, one beat 15'h0000 with last → `out_data` = −15 (16'hFFF1), `out_mode` = 1.
- Mode 0, three beats of 15'h00FF, last on the third, with one idle cycle between beats 1 and 2 → `out_data` = 24.
- ACC_W=5, mode 0, three beats of 15'h7FFF → `out_data` = 31, `out_sat` = 1. The following packet of 15'h0001 → 1, `out_sat` = 0.
- Back-to-back one-beat packets with `out_ready` = 0 for 3 cycles:
  - `in_ready` drops the cycle after `out_valid` rises.
  - `out_data` holds.
  - After `out_ready` goes high, results arrive in order with no loss.
- IN_W=40 (G=3, padded), mode 1, all-ones beat then `reset` pulsed mid-packet → no output. The next beat of all-ones with last → `out_data` = 40.

Source files
------------

// File: rtl/npu_pop_pkg.sv
// rtl/npu_pop_pkg.sv - shared constants, mode encodings and limit helpers for the popcount datapath
package npu_pop_pkg;

  localparam int GROUP_W = 15;
  localparam int GCNT_W  = 4;

  typedef enum logic {
    MODE_POP = 1'b0,
    MODE_BIP = 1'b1
  } mode_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic longint sat_umax(input int w);
    return (longint'(1) << w) - 1;
  endfunction

  function automatic longint sat_smax(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  function automatic longint sat_smin(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/popcount_accumulator_if.sv
// rtl/popcount_accumulator_if.sv - input beat stream and result stream of the popcount accumulator
interface popcount_accumulator_if #(
  parameter int IN_W  = 15,
  parameter int ACC_W = 16
);
  logic [IN_W-1:0]  in_data;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic             in_mode;
  logic [ACC_W-1:0] out_data;
  logic             out_sat;
  logic             out_mode;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, in_last, in_mode, out_ready,
    output in_ready, out_data, out_sat, out_mode, out_valid
  );

  modport master (
    output in_data, in_valid, in_last, in_mode, out_ready,
    input  in_ready, out_data, out_sat, out_mode, out_valid
  );
endinterface

// File: rtl/popcount_group.sv
// rtl/popcount_group.sv - 15-to-4 bit counter: five full adders, two 5:3 compressors, final add
module popcount_group
  import npu_pop_pkg::*;
(
  input  logic [GROUP_W-1:0] i_bits,
  output logic [GCNT_W-1:0]  o_count
);

  logic [4:0] w_fa_s;
  logic [4:0] w_fa_c;
  logic [2:0] w_s_cnt;
  logic [2:0] w_c_cnt;

  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Two chained full adders; their carries share weight 2 and combine into bits 1 and 2.
  function automatic logic [2:0] c53(input logic [4:0] x);
    logic [1:0] f0;
    logic [1:0] f1;
    f0 = fa(x[0], x[1], x[2]);
    f1 = fa(f0[0], x[3], x[4]);
    return {f0[1] & f1[1], f0[1] ^ f1[1], f1[0]};
  endfunction

  always_comb begin
    w_fa_s = '0;
    w_fa_c = '0;
    for (int i = 0; i < 5; i++) begin
      {w_fa_c[i], w_fa_s[i]} = fa(i_bits[3*i], i_bits[3*i+1], i_bits[3*i+2]);
    end
  end

  assign w_s_cnt = c53(w_fa_s);
  assign w_c_cnt = c53(w_fa_c);
  assign o_count = {1'b0, w_s_cnt} + {w_c_cnt, 1'b0};

endmodule

// File: rtl/popcount_accumulator.sv
// rtl/popcount_accumulator.sv - pipelined per-packet popcount / bipolar dot-product accumulator
module popcount_accumulator
  import npu_pop_pkg::*;
#(
  parameter int IN_W  = 15,
  parameter int ACC_W = 16
) (
  input logic clk,
  input logic reset,
  popcount_accumulator_if.slave bus
);

  localparam int G     = (IN_W + GROUP_W - 1) / GROUP_W;
  localparam int PAD_W = G * GROUP_W;
  localparam int POP_W = clog2(IN_W + 1);
  localparam int EXT_W = ACC_W + 2;

  localparam logic signed [EXT_W-1:0] L_IN_W = EXT_W'(IN_W);
  localparam logic signed [EXT_W-1:0] L_UMAX = EXT_W'(sat_umax(ACC_W));
  localparam logic signed [EXT_W-1:0] L_SMAX = EXT_W'(sat_smax(ACC_W));
  localparam logic signed [EXT_W-1:0] L_SMIN = EXT_W'(sat_smin(ACC_W));

  logic                     w_stall;
  logic                     w_accept;
  mode_e                    w_beat_mode;
  logic [PAD_W-1:0]         w_padded;
  logic [GCNT_W-1:0]        w_gcnt [G];
  logic [POP_W-1:0]         w_pop;
  logic                     w_bip;
  logic signed [EXT_W-1:0]  w_acc_ext;
  logic signed [EXT_W-1:0]  w_pop_ext;
  logic signed [EXT_W-1:0]  w_contrib;
  logic signed [EXT_W-1:0]  w_sum;
  logic signed [EXT_W-1:0]  w_clamped;
  logic                     w_clamp;
  logic [ACC_W-1:0]         w_acc_next;
  logic                     w_sat_next;

  logic                     r_first;
  mode_e                    r_pkt_mode;
  logic [GCNT_W-1:0]        r_s1_cnt [G];
  logic                     r_s1_valid;
  logic                     r_s1_last;
  mode_e                    r_s1_mode;
  logic [POP_W-1:0]         r_s2_pop;
  logic                     r_s2_valid;
  logic                     r_s2_last;
  mode_e                    r_s2_mode;
  logic [ACC_W-1:0]         r_acc;
  logic                     r_sat;
  logic [ACC_W-1:0]         r_out_data;
  logic                     r_out_sat;
  mode_e                    r_out_mode;
  logic                     r_out_valid;

  // The whole pipeline freezes while a result waits, so nothing in flight can be lost.
  assign w_stall      = r_out_valid & ~bus.out_ready;
  assign w_accept     = bus.in_valid & ~w_stall;
  assign bus.in_ready = ~w_stall;
  assign w_beat_mode  = r_first ? mode_e'(bus.in_mode) : r_pkt_mode;
  assign w_padded     = PAD_W'(bus.in_data);

  for (genvar g = 0; g < G; g++) begin : g_grp
    popcount_group u_grp (
      .i_bits  (w_padded[g*GROUP_W +: GROUP_W]),
      .o_count (w_gcnt[g])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_first    <= 1'b1;
      r_pkt_mode <= MODE_POP;
    end else if (w_accept) begin
      r_first    <= bus.in_last;
      r_pkt_mode <= w_beat_mode;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= MODE_POP;
      for (int g = 0; g < G; g++) r_s1_cnt[g] <= '0;
    end else if (!w_stall) begin
      r_s1_valid <= w_accept;
      r_s1_last  <= bus.in_last;
      r_s1_mode  <= w_beat_mode;
      for (int g = 0; g < G; g++) r_s1_cnt[g] <= w_gcnt[g];
    end
  end

  always_comb begin
    w_pop = '0;
    for (int g = 0; g < G; g++) w_pop = w_pop + POP_W'(r_s1_cnt[g]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_pop   <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_mode  <= MODE_POP;
    end else if (!w_stall) begin
      r_s2_pop   <= w_pop;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_mode  <= r_s1_mode;
    end
  end

  // Two guard bits let the raw sum overshoot either limit before clamping.
  always_comb begin
    w_bip     = (r_s2_mode == MODE_BIP);
    w_acc_ext = $signed({{2{w_bip & r_acc[ACC_W-1]}}, r_acc});
    w_pop_ext = EXT_W'(r_s2_pop);
    w_contrib = w_bip ? (w_pop_ext <<< 1) - L_IN_W : w_pop_ext;
    w_sum     = w_acc_ext + w_contrib;
    w_clamped = w_sum;
    w_clamp   = 1'b0;
    if (w_bip) begin
      if (w_sum > L_SMAX) begin
        w_clamped = L_SMAX;
        w_clamp   = 1'b1;
      end else if (w_sum < L_SMIN) begin
        w_clamped = L_SMIN;
        w_clamp   = 1'b1;
      end
    end else if (w_sum > L_UMAX) begin
      w_clamped = L_UMAX;
      w_clamp   = 1'b1;
    end
    w_acc_next = ACC_W'(w_clamped);
    w_sat_next = r_sat | w_clamp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc       <= '0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      r_out_mode  <= MODE_POP;
      r_out_valid <= 1'b0;
    end else if (!w_stall) begin
      r_out_valid <= r_s2_valid & r_s2_last;
      if (r_s2_valid) begin
        if (r_s2_last) begin
          r_acc      <= '0;
          r_sat      <= 1'b0;
          r_out_data <= w_acc_next;
          r_out_sat  <= w_sat_next;
          r_out_mode <= r_s2_mode;
        end else begin
          r_acc      <= w_acc_next;
          r_sat      <= w_sat_next;
        end
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_sat   = r_out_sat;
  assign bus.out_mode  = r_out_mode;
  assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_popcount_accumulator.sv
// tb/tb_popcount_accumulator.sv - self-checking bench with a packet-level reference model
module tb_popcount_accumulator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [14:0] s_data  = '0;
  logic        s_valid = 1'b0;
  logic        s_last  = 1'b0;
  logic        s_mode  = 1'b0;
  logic        s_ordy  = 1'b1;
  logic [39:0] c_data  = '0;
  logic        c_valid = 1'b0;
  logic        c_last  = 1'b0;
  logic        c_mode  = 1'b0;

  popcount_accumulator_if #(.IN_W(15), .ACC_W(16)) if_a ();
  popcount_accumulator_if #(.IN_W(15), .ACC_W(5))  if_b ();
  popcount_accumulator_if #(.IN_W(40), .ACC_W(16)) if_c ();

  assign if_a.in_data = s_data;  assign if_a.in_valid = s_valid; assign if_a.in_last = s_last;
  assign if_a.in_mode = s_mode;  assign if_a.out_ready = s_ordy;
  assign if_b.in_data = s_data;  assign if_b.in_valid = s_valid; assign if_b.in_last = s_last;
  assign if_b.in_mode = s_mode;  assign if_b.out_ready = s_ordy;
  assign if_c.in_data = c_data;  assign if_c.in_valid = c_valid; assign if_c.in_last = c_last;
  assign if_c.in_mode = c_mode;  assign if_c.out_ready = 1'b1;

  popcount_accumulator #(.IN_W(15), .ACC_W(16)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  popcount_accumulator #(.IN_W(15), .ACC_W(5))  dut_b (.clk(clk), .reset(reset), .bus(if_b));
  popcount_accumulator #(.IN_W(40), .ACC_W(16)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    longint d;
    bit     s;
    bit     m;
  } res_t;

  res_t   q_a[$];
  res_t   q_b[$];
  longint m_acc_a = 0;
  longint m_acc_b = 0;
  bit     m_sat_a = 0;
  bit     m_sat_b = 0;
  bit     m_first = 1;
  bit     m_mode  = 0;

  function automatic void model_add(input int w, input bit bip, input int pop,
                                    inout longint acc, inout bit sat);
    longint v, hi, lo;
    v  = acc + (bip ? 2 * pop - 15 : pop);
    hi = bip ? (longint'(1) << (w - 1)) - 1 : (longint'(1) << w) - 1;
    lo = bip ? -(longint'(1) << (w - 1)) : 0;
    if (v > hi) begin v = hi; sat = 1; end
    else if (v < lo) begin v = lo; sat = 1; end
    acc = v;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      q_a.delete(); q_b.delete();
      m_acc_a = 0; m_acc_b = 0; m_sat_a = 0; m_sat_b = 0; m_first = 1; m_mode = 0;
    end else begin
      chk("in_ready_a", longint'(if_a.in_ready), longint'(!(if_a.out_valid && !s_ordy)));
      chk("in_ready_b", longint'(if_b.in_ready), longint'(!(if_b.out_valid && !s_ordy)));
      if (if_a.out_valid) begin
        if (q_a.size() == 0) chk("a_unexpected_out", 1, 0);
        else begin
          chk("a_data", longint'(if_a.out_data), q_a[0].d & 64'hFFFF);
          chk("a_sat", longint'(if_a.out_sat), longint'(q_a[0].s));
          chk("a_mode", longint'(if_a.out_mode), longint'(q_a[0].m));
          if (s_ordy) void'(q_a.pop_front());
        end
      end
      if (if_b.out_valid) begin
        if (q_b.size() == 0) chk("b_unexpected_out", 1, 0);
        else begin
          chk("b_data", longint'(if_b.out_data), q_b[0].d & 64'h1F);
          chk("b_sat", longint'(if_b.out_sat), longint'(q_b[0].s));
          chk("b_mode", longint'(if_b.out_mode), longint'(q_b[0].m));
          if (s_ordy) void'(q_b.pop_front());
        end
      end
      if (s_valid && if_a.in_ready) begin
        if (m_first) m_mode = s_mode;
        model_add(16, m_mode, $countones(s_data), m_acc_a, m_sat_a);
        model_add(5, m_mode, $countones(s_data), m_acc_b, m_sat_b);
        if (s_last) begin
          q_a.push_back('{d: m_acc_a, s: m_sat_a, m: m_mode});
          q_b.push_back('{d: m_acc_b, s: m_sat_b, m: m_mode});
          m_acc_a = 0; m_acc_b = 0; m_sat_a = 0; m_sat_b = 0;
        end
        m_first = s_last;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [14:0] d, input bit l, input bit m);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    s_data = d; s_last = l; s_mode = m; s_valid = 1'b1;
    while (!ok) begin
      @(negedge clk);
      ok = if_a.in_ready;
      tick();
      n++;
      if (n > 200 && !ok) begin
        chk("send_timeout", 1, 0);
        ok = 1;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic long_pkt(input logic [14:0] d, input bit m, input int n, input bit l);
    for (int i = 0; i < n; i++) send(d, l && (i == n - 1), m);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(if_a.out_valid), 0);
    chk("rst_out_data", longint'(if_a.out_data), 0);
    chk("rst_out_sat", longint'(if_a.out_sat), 0);
    chk("rst_out_mode", longint'(if_a.out_mode), 0);
    chk("rst_in_ready", longint'(if_a.in_ready), 1);
    reset = 1'b0;
    idle(1);

    send(15'h7FFF, 1, 0);
    chk("t1_valid_t0", longint'(if_a.out_valid), 0);
    tick();
    chk("t1_valid_t1", longint'(if_a.out_valid), 0);
    tick();
    chk("t1_valid_t2", longint'(if_a.out_valid), 1);
    chk("t1_data", longint'(if_a.out_data), 15);
    chk("t1_sat", longint'(if_a.out_sat), 0);
    idle(3);

    send(15'h0000, 1, 1);
    idle(2);
    chk("t2_data", longint'(if_a.out_data), 64'hFFF1);
    chk("t2_mode", longint'(if_a.out_mode), 1);
    idle(3);

    send(15'h00FF, 0, 0);
    idle(1);
    send(15'h00FF, 0, 1);
    send(15'h00FF, 1, 1);
    idle(2);
    chk("t3_data", longint'(if_a.out_data), 24);
    chk("t3_mode", longint'(if_a.out_mode), 0);
    idle(3);

    long_pkt(15'h7FFF, 0, 3, 1);
    idle(2);
    chk("t4_a_data", longint'(if_a.out_data), 45);
    chk("t4_b_data", longint'(if_b.out_data), 31);
    chk("t4_b_sat", longint'(if_b.out_sat), 1);
    idle(1);
    send(15'h0001, 1, 0);
    idle(2);
    chk("t4_b_next_data", longint'(if_b.out_data), 1);
    chk("t4_b_next_sat", longint'(if_b.out_sat), 0);
    idle(3);

    s_ordy = 1'b0;
    send(15'h0001, 1, 0);
    send(15'h0003, 1, 0);
    send(15'h0007, 1, 0);
    chk("t5_valid", longint'(if_a.out_valid), 1);
    chk("t5_in_ready", longint'(if_a.in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_hold_data", longint'(if_a.out_data), 1);
    end
    s_ordy = 1'b1;
    tick();
    chk("t5_second_valid", longint'(if_a.out_valid), 1);
    chk("t5_second_data", longint'(if_a.out_data), 2);
    tick();
    chk("t5_third_data", longint'(if_a.out_data), 3);
    tick();
    chk("t5_drained", longint'(if_a.out_valid), 0);
    idle(2);

    long_pkt(15'h7FFF, 0, 4400, 1);
    idle(2);
    chk("sat_u_data", longint'(if_a.out_data), 65535);
    chk("sat_u_sat", longint'(if_a.out_sat), 1);
    idle(2);
    long_pkt(15'h7FFF, 1, 2200, 0);
    long_pkt(15'h0000, 1, 5, 1);
    idle(2);
    chk("sat_s_after_data", longint'(if_a.out_data), 32692);
    chk("sat_s_after_sat", longint'(if_a.out_sat), 1);
    idle(2);
    long_pkt(15'h0000, 1, 2200, 1);
    idle(2);
    chk("sat_s_neg_data", longint'(if_a.out_data), 64'h8000);
    idle(3);

    c_data = '1; c_mode = 1'b1; c_last = 1'b0; c_valid = 1'b1;
    chk("c_in_ready", longint'(if_c.in_ready), 1);
    tick();
    c_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("c_no_output", longint'(if_c.out_valid), 0);
    end
    c_last = 1'b1; c_valid = 1'b1;
    tick();
    c_valid = 1'b0; c_last = 1'b0;
    tick();
    tick();
    chk("c_valid", longint'(if_c.out_valid), 1);
    chk("c_data", longint'(if_c.out_data), 40);
    chk("c_mode", longint'(if_c.out_mode), 1);
    idle(3);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      s_valid = ($urandom % 4) != 0;
      s_data  = 15'($urandom);
      s_last  = ($urandom % 3) == 0;
      s_mode  = 1'($urandom);
      s_ordy  = ($urandom % 3) != 0;
      reset   = ($urandom % 700) == 0;
      tick();
    end
    s_valid = 1'b0; s_ordy = 1'b1; reset = 1'b0;
    for (int i = 0; i < 50 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    chk("drain_a", longint'(q_a.size()), 0);
    chk("drain_b", longint'(q_b.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
